// File: rtl/ins_fetcher_pkg.sv
// Shared widths, reset PC and fetch FSM encodings for the instruction fetcher.
package ins_fetcher_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INS_WIDTH  = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ins_fetcher_queue.sv
// In-order fetch queue: show-ahead FIFO of {instruction, pc, predicted-jump}.
// Head outputs read as zero while the queue is empty.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   push,
  input  logic [INS_W-1:0]       push_ins,
  input  logic [ADDR_W-1:0]      push_pc,
  input  logic                   push_jump,
  input  logic                   pop,
  output logic [INS_W-1:0]       head_ins,
  output logic [ADDR_W-1:0]      head_pc,
  output logic                   head_jump,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INS_W-1:0]  ins_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [DEPTH-1:0]  jump_mem;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_ins  = empty ? '0 : ins_mem[head_ptr];
  assign head_pc   = empty ? '0 : pc_mem[head_ptr];
  assign head_jump = empty ? 1'b0 : jump_mem[head_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (en) begin
      if (clear) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + PTR_W'(1);
        if (pop)  head_ptr <= head_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (en && push && !clear) begin
      ins_mem[tail_ptr]  <= push_ins;
      pc_mem[tail_ptr]   <= push_pc;
      jump_mem[tail_ptr] <= push_jump;
    end
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    (en && !clear) |-> !(pop && empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    (en && !clear) |-> !(push && full));

endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: owns the fetch PC, keeps one ICache request in flight, routes
// each response through the Predictor and into the fetch queue.
//
//   state   | meaning
//   IDLE    | no request outstanding; issue when the queue has room
//   WAIT    | request to pc outstanding; response is pushed and pc advances
//   DISCARD | request outstanding but stale after a flush; drop its response
module ins_fetcher #(
  parameter int                ADDR_W      = ins_fetcher_pkg::ADDR_WIDTH,
  parameter int                INS_W       = ins_fetcher_pkg::INS_WIDTH,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = ins_fetcher_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              ic_req_valid,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_resp_valid,
  input  logic [INS_W-1:0]  ic_resp_ins,
  output logic [ADDR_W-1:0] pred_pc_cur,
  output logic [INS_W-1:0]  pred_ins_cur,
  input  logic              pred_enable,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic              pred_jump,
  output logic              disp_valid,
  output logic [INS_W-1:0]  disp_ins,
  output logic [ADDR_W-1:0] disp_pc,
  output logic              disp_pred_jump,
  input  logic              disp_ready,
  input  logic              rob_flush,
  input  logic [ADDR_W-1:0] rob_redirect_pc
);
  import ins_fetcher_pkg::*;

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              q_push, q_pop, q_clear;
  logic              q_empty, q_full;
  logic [CNT_W-1:0]  q_count;

  assign ic_req_addr  = pc;
  assign pred_pc_cur  = pc;
  assign pred_ins_cur = ic_resp_ins;
  assign disp_valid   = rst & rdy & ~q_empty;
  assign q_pop        = disp_valid & disp_ready;

  // Fetch PC and FSM state; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (rdy) begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Request issue, response acceptance and redirect; flush overrides all.
  always_comb begin
    ic_req_valid = 1'b0;
    state_nxt    = state;
    pc_nxt       = pc;
    q_push       = 1'b0;
    q_clear      = 1'b0;
    case (state)
      IDLE: begin
        ic_req_valid = rst & rdy & ~rob_flush & (q_count < CNT_W'(QUEUE_DEPTH));
        if (ic_req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (rob_flush) begin
          state_nxt = ic_resp_valid ? IDLE : DISCARD;
        end else if (ic_resp_valid) begin
          q_push    = 1'b1;
          pc_nxt    = pred_enable ? pred_pc : pc + ADDR_W'(4);
          state_nxt = IDLE;
        end
      end
      DISCARD: begin
        // A response here retires the stale request even in a flush cycle,
        // otherwise nothing would ever bring the FSM back to IDLE.
        if (ic_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rob_flush) begin
      q_clear = 1'b1;
      pc_nxt  = rob_redirect_pc;
    end
  end

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .ADDR_W (ADDR_W),
    .INS_W  (INS_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .clear     (q_clear),
    .push      (q_push),
    .push_ins  (ic_resp_ins),
    .push_pc   (pc),
    .push_jump (pred_jump),
    .pop       (q_pop),
    .head_ins  (disp_ins),
    .head_pc   (disp_pc),
    .head_jump (disp_pred_jump),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  a_full_blocks_issue: assert property (@(posedge clk) disable iff (!rst)
    q_full |-> !ic_req_valid);

endmodule
